// File: rtl/rfc_vote_aggregator.sv
// rfc_vote_aggregator: majority vote over N_TREES tree labels with timeout, lowest-index tie-break and valid/ready result.
// Ports: clk, reset (async, active-low); start launches an inference from IDLE; tree_start pulses once to launch the trees;
// tree_done/tree_label carry per-tree completion and label (tree i at [i*LABEL_W +: LABEL_W]); busy is high outside IDLE;
// result_valid/result_ready handshake result_label, result_votes and timeout_err.
// Optional macro RFC_VOTE_MARGIN_EN adds result_margin (winning count minus second-highest count).
module rfc_vote_aggregator #(
  parameter int N_TREES     = 8,
  parameter int N_CLASSES   = 4,
  parameter int LABEL_W     = $clog2(N_CLASSES),
  parameter int CNT_W       = $clog2(N_TREES + 1),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       tree_start,
  input  logic [N_TREES-1:0]         tree_done,
  input  logic [N_TREES*LABEL_W-1:0] tree_label,
  output logic                       busy,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [LABEL_W-1:0]         result_label,
  output logic [CNT_W-1:0]           result_votes,
  output logic                       timeout_err
`ifdef RFC_VOTE_MARGIN_EN
  ,
  output logic [CNT_W-1:0]           result_margin
`endif
);
  localparam int TIDX_W = $clog2(N_TREES);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LABEL_W:0] NCL = (LABEL_W + 1)'(N_CLASSES);
  typedef enum logic [2:0] {IDLE, COLLECT, TALLY, ARGMAX, HOLD} state_t;
  state_t st, st_n;
  logic [N_TREES-1:0] mask, mask_n;
  logic [LABEL_W-1:0] lbl_q [N_TREES];
  logic [CNT_W-1:0] cnt [N_CLASSES];
  logic [TIDX_W-1:0] tidx;
  logic [LABEL_W-1:0] cidx;
  logic [TO_W-1:0] tcnt;
  logic [CNT_W-1:0] best_cnt, cur, nb_cnt;
  logic [LABEL_W-1:0] best_idx, nb_idx, t_lbl;
  logic all_done, to_hit, t_last, c_last, gt, t_vote;
`ifdef RFC_VOTE_MARGIN_EN
  logic [CNT_W-1:0] sec_cnt, ns_cnt;
  // A new best demotes the old best to second; otherwise the candidate may still beat the second (ties land here, giving margin 0).
  assign ns_cnt = gt ? best_cnt : (cur > sec_cnt ? cur : sec_cnt);
`endif
  assign busy = st != IDLE;
  always_comb begin
    // mask_n includes this edge's new dones so completion is seen on the same edge it happens.
    mask_n = mask | tree_done;
    all_done = &mask_n;
    to_hit = tcnt == TO_W'(TIMEOUT_CYC - 1);
    t_last = tidx == TIDX_W'(N_TREES - 1);
    c_last = cidx == LABEL_W'(N_CLASSES - 1);
    t_lbl = lbl_q[tidx];
    t_vote = mask[tidx] && ({1'b0, t_lbl} < NCL);
    cur = cnt[cidx];
    gt = cur > best_cnt;
    nb_cnt = gt ? cur : best_cnt;
    nb_idx = gt ? cidx : best_idx;
  end
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = start ? COLLECT : IDLE;
      COLLECT: st_n = (all_done || to_hit) ? TALLY : COLLECT;
      TALLY:   st_n = t_last ? ARGMAX : TALLY;
      ARGMAX:  st_n = c_last ? HOLD : ARGMAX;
      HOLD:    st_n = result_ready ? IDLE : HOLD;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tree_start <= 1'b0;
      result_valid <= 1'b0;
      result_label <= '0;
      result_votes <= '0;
      timeout_err <= 1'b0;
      mask <= '0;
      tcnt <= '0;
      tidx <= '0;
      cidx <= '0;
      best_cnt <= '0;
      best_idx <= '0;
      for (int i = 0; i < N_TREES; i++) lbl_q[i] <= '0;
      for (int c = 0; c < N_CLASSES; c++) cnt[c] <= '0;
`ifdef RFC_VOTE_MARGIN_EN
      sec_cnt <= '0;
      result_margin <= '0;
`endif
    end else begin
      tree_start <= st == IDLE && start;
      case (st)
        IDLE:
          if (start) begin
            mask <= '0;
            tcnt <= '0;
            tidx <= '0;
            cidx <= '0;
            best_cnt <= '0;
            best_idx <= '0;
            timeout_err <= 1'b0;
            result_label <= '0;
            result_votes <= '0;
            for (int c = 0; c < N_CLASSES; c++) cnt[c] <= '0;
`ifdef RFC_VOTE_MARGIN_EN
            sec_cnt <= '0;
            result_margin <= '0;
`endif
          end
        COLLECT: begin
          for (int i = 0; i < N_TREES; i++)
            if (tree_done[i] && !mask[i]) lbl_q[i] <= tree_label[i*LABEL_W +: LABEL_W];
          mask <= mask_n;
          tcnt <= tcnt + TO_W'(1);
          if (!all_done && to_hit) timeout_err <= 1'b1;
        end
        TALLY: begin
          if (t_vote) cnt[t_lbl] <= cnt[t_lbl] + CNT_W'(1);
          tidx <= t_last ? '0 : tidx + TIDX_W'(1);
        end
        ARGMAX: begin
          best_cnt <= nb_cnt;
          best_idx <= nb_idx;
          cidx <= c_last ? '0 : cidx + LABEL_W'(1);
`ifdef RFC_VOTE_MARGIN_EN
          sec_cnt <= ns_cnt;
          if (c_last) result_margin <= nb_cnt - ns_cnt;
`endif
          if (c_last) begin
            result_valid <= 1'b1;
            result_label <= nb_idx;
            result_votes <= nb_cnt;
          end
        end
        HOLD:
          if (result_ready) result_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
